j1_io_responder: RTL and testbench

- Memory-mapped I/O target for the J1 core. It answers the core's io_rd/io_wr strobes, using the core's mem_addr and dout outputs as address and write data, and returns io_din.
- It provides:
  - a GPIO output register
  - a synchronised GPIO input
  - an 8N1 UART transmitter fed by a FIFO
  - a 64-bit free-running cycle counter with a coherent high-word snapshot
- It sits between the CPU top level and board pins.

---
 rtl/j1_io_responder.sv | 170 +++++++++++++++++
 tb/tb_j1_io_responder.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/j1_io_responder.sv
// j1_io_responder: J1 memory-mapped I/O target with GPIO, FIFO-fed 8N1 UART TX and optional cycle counter.
// Define J1IO_CYCLE_COUNTER_EN to add the 64-bit cycle counter at 0x3000/0x3004.
module j1_io_responder #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_LOG2 = 4
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic        io_rd,
    input  logic        io_wr,
    input  logic [15:0] io_addr,
    input  logic [31:0] io_dout,
    output logic [31:0] io_din,
    input  logic [7:0]  gpio_in,
    output logic [7:0]  gpio_out,
    output logic        uart_tx
);
    localparam int DEPTH = 1 << FIFO_LOG2;
    localparam int LW = FIFO_LOG2 + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic sel_gpo, sel_gpi, sel_data, sel_stat, sel_clo, sel_chi;
    assign sel_gpo  = io_addr == 16'h1000;
    assign sel_gpi  = io_addr == 16'h1004;
    assign sel_data = io_addr == 16'h2000;
    assign sel_stat = io_addr == 16'h2004;
    assign sel_clo  = io_addr == 16'h3000;
    assign sel_chi  = io_addr == 16'h3004;

    logic unused_ok;
    assign unused_ok = ^io_dout[31:8];

    logic [7:0] sync1, sync2;
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            gpio_out <= '0;
            sync1    <= '0;
            sync2    <= '0;
        end else begin
            sync1 <= gpio_in;
            sync2 <= sync1;
            if (io_wr && sel_gpo)
                gpio_out <= io_dout[7:0];
        end
    end

    logic [7:0]           mem [DEPTH];
    logic [FIFO_LOG2-1:0] wp, rp;
    logic [LW-1:0]        level;
    logic                 ovf, full, empty, push_req, push, pop;
    state_t               state, state_nx;

    assign full     = level == LW'(DEPTH);
    assign empty    = level == '0;
    assign push_req = io_wr && sel_data;
    assign push     = push_req && !full;
    assign pop      = state == IDLE && !empty;

    // A push against a full FIFO is dropped even when the shifter pops on the same edge.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wp    <= '0;
            rp    <= '0;
            level <= '0;
            ovf   <= 1'b0;
        end else begin
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
            if (io_wr && sel_stat)
                ovf <= 1'b0;
            else if (push_req && full)
                ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= io_dout[7:0];
    end

    logic [7:0]    shift, shift_nx;
    logic [2:0]    bit_cnt, bit_nx;
    logic [BW-1:0] baud, baud_nx;
    logic          baud_done, tx_nx;

    assign baud_done = baud == BW'(CLKS_PER_BIT - 1);

    always_comb begin
        state_nx = state;
        shift_nx = shift;
        bit_nx   = bit_cnt;
        baud_nx  = baud_done ? '0 : baud + 1'b1;
        case (state)
            IDLE: begin
                baud_nx = '0;
                if (!empty) begin
                    state_nx = START;
                    shift_nx = mem[rp];
                    bit_nx   = '0;
                end
            end
            START: state_nx = baud_done ? DATA : START;
            DATA: begin
                if (baud_done) begin
                    shift_nx = shift >> 1;
                    bit_nx   = bit_cnt + 1'b1;
                    state_nx = bit_cnt == 3'd7 ? STOP : DATA;
                end
            end
            STOP: state_nx = baud_done ? IDLE : STOP;
        endcase
        tx_nx = state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
    end

    // uart_tx follows the current state one edge later, so a fresh push shows a start bit at N+2.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            baud    <= '0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_nx;
            shift   <= shift_nx;
            bit_cnt <= bit_nx;
            baud    <= baud_nx;
            uart_tx <= tx_nx;
        end
    end

    logic [31:0] cyc_lo, cyc_hi;
`ifdef J1IO_CYCLE_COUNTER_EN
    logic [63:0] count;
    logic [31:0] snap_hi;
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            count   <= '0;
            snap_hi <= '0;
        end else begin
            count <= count + 64'd1;
            if (io_rd && sel_clo)
                snap_hi <= count[63:32];
        end
    end
    assign cyc_lo = count[31:0];
    assign cyc_hi = snap_hi;
`else
    assign cyc_lo = '0;
    assign cyc_hi = '0;
`endif

    logic [31:0] status;
    assign status = {16'h0, 8'(level), 4'h0, ovf, state != IDLE, empty, full};

    assign io_din = !io_rd   ? '0 :
                    sel_gpo  ? {24'h0, gpio_out} :
                    sel_gpi  ? {24'h0, sync2} :
                    sel_stat ? status :
                    sel_clo  ? cyc_lo :
                    sel_chi  ? cyc_hi : '0;
endmodule

// File: tb/tb_j1_io_responder.sv
// tb_j1_io_responder: directed bench with a UART byte scoreboard for j1_io_responder (CLKS_PER_BIT=4, depth 4).
module tb_j1_io_responder;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic        io_rd = 1'b0;
    logic        io_wr = 1'b0;
    logic [15:0] io_addr = '0;
    logic [31:0] io_dout = '0;
    logic [31:0] io_din;
    logic [7:0]  gpio_in = '0;
    logic [7:0]  gpio_out;
    logic        uart_tx;

    int errors = 0;
    int checks = 0;
    int frames = 0;
    bit mon_en = 1'b1;
    logic [7:0] exp_q[$];
    logic [7:0] mon_b;

    j1_io_responder #(.CLKS_PER_BIT(CPB), .FIFO_LOG2(2)) dut (
        .clk(clk), .resetq(resetq), .io_rd(io_rd), .io_wr(io_wr), .io_addr(io_addr),
        .io_dout(io_dout), .io_din(io_din), .gpio_in(gpio_in), .gpio_out(gpio_out), .uart_tx(uart_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d);
        io_wr = 1'b1; io_addr = a; io_dout = d;
        tick();
        io_wr = 1'b0; io_addr = '0; io_dout = '0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [31:0] d);
        io_rd = 1'b1; io_addr = a;
        #1 d = io_din;
        tick();
        io_rd = 1'b0; io_addr = '0;
    endtask

    task automatic peek(input logic [15:0] a, output logic [31:0] d);
        io_rd = 1'b1; io_addr = a;
        #1 d = io_din;
        io_rd = 1'b0; io_addr = '0;
    endtask

    // Decodes each frame mid-bit and pops the expected byte from the scoreboard.
    initial forever begin
        @(negedge clk);
        if (mon_en && resetq && uart_tx === 1'b0) begin
            repeat (2) @(negedge clk);
            chk("start_bit", {31'h0, uart_tx}, 32'h0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                mon_b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            chk("stop_bit", {31'h0, uart_tx}, 32'h1);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL frame_extra: observed=%h expected=none", mon_b);
            end else
                chk("frame_byte", {24'h0, mon_b}, {24'h0, exp_q.pop_front()});
            frames++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        logic [7:0] bytes [6];
        int lows;
        bytes = '{8'h81, 8'h42, 8'hC3, 8'h24, 8'hE5, 8'h66};
        repeat (3) @(posedge clk);
        #1 resetq = 1'b1;
        chk("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
        chk("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
        peek(16'h2004, d);
        chk("rst_status", d, 32'h2);
        tick();

        wr(16'h1000, 32'h1234_56A5);
        chk("gpio_out_wr", {24'h0, gpio_out}, 32'hA5);
        rd(16'h1000, d);
        chk("gpio_out_rd", d, 32'h0000_00A5);

        rd(16'h0FFC, d);
        chk("unmapped_rd", d, 32'h0);
        wr(16'h0FFC, 32'hFFFF_FFFF);
        rd(16'h1000, d);
        chk("unmapped_wr_gpio", d, 32'hA5);
        peek(16'h2004, d);
        chk("unmapped_wr_status", d, 32'h2);
        tick();
        foreach (bytes[i]) begin
            io_addr = 16'h1000 + 16'(i * 4);
            #1 chk("rd_low_zero", io_din, 32'h0);
            tick();
        end
        io_addr = 16'h2004;
        #1 chk("rd_low_status", io_din, 32'h0);
        tick();

        gpio_in = 8'h3C;
        peek(16'h1004, d);
        chk("gpio_in_e1", d, 32'h0);
        tick();
        peek(16'h1004, d);
        chk("gpio_in_e2", d, 32'h0);
        tick();
        peek(16'h1004, d);
        chk("gpio_in_e3", d, 32'h3C);
        tick();

`ifdef J1IO_CYCLE_COUNTER_EN
        force dut.count = 64'h0000_0000_FFFF_FFFE;
        release dut.count;
        rd(16'h3000, d);
        chk("cyc_lo", d, 32'hFFFF_FFFE);
        tick();
        rd(16'h3004, d);
        chk("cyc_hi_snap", d, 32'h0);
        rd(16'h3000, d);
        chk("cyc_lo_wrapped", d, 32'h1);
        rd(16'h3004, d);
        chk("cyc_hi_new", d, 32'h1);
`else
        rd(16'h3000, d);
        chk("cyc_lo_off", d, 32'h0);
        rd(16'h3004, d);
        chk("cyc_hi_off", d, 32'h0);
`endif

        wr(16'h2000, 32'h55);
        exp_q.push_back(8'h55);
        chk("tx_n0", {31'h0, uart_tx}, 32'h1);
        tick();
        chk("tx_n1", {31'h0, uart_tx}, 32'h1);
        tick();
        chk("tx_bit0", {31'h0, uart_tx}, 32'h0);
        peek(16'h2004, d);
        chk("status_busy", d, 32'h6);
        for (int k = 1; k < 10; k++) begin
            repeat (CPB) tick();
            chk($sformatf("tx_bit%0d", k), {31'h0, uart_tx}, k % 2);
        end
        repeat (8) tick();
        peek(16'h2004, d);
        chk("status_idle", d, 32'h2);
        tick();

        foreach (bytes[i]) begin
            wr(16'h2000, {24'h0, bytes[i]});
            if (i < 5)
                exp_q.push_back(bytes[i]);
        end
        peek(16'h2004, d);
        chk("status_overflow", d, 32'h0000_040D);
        tick();
        wr(16'h2004, 32'h0);
        peek(16'h2004, d);
        chk("status_ovf_clear", d, 32'h0000_0405);
        tick();
        for (int c = 0; c < 400 && frames < 6; c++)
            tick();
        chk("frames_tx", frames, 32'd6);
        chk("queue_empty", exp_q.size(), 32'd0);
        repeat (CPB) tick();
        peek(16'h2004, d);
        chk("status_drained", d, 32'h2);
        tick();

        mon_en = 1'b0;
        wr(16'h2000, 32'h00);
        repeat (10) tick();
        chk("midframe_low", {31'h0, uart_tx}, 32'h0);
        #2 resetq = 1'b0;
        #1 chk("async_rst_tx", {31'h0, uart_tx}, 32'h1);
        chk("async_rst_gpio", {24'h0, gpio_out}, 32'h0);
        repeat (2) @(posedge clk);
        #1 resetq = 1'b1;
        lows = 0;
        for (int c = 0; c < 60; c++) begin
            tick();
            if (uart_tx !== 1'b1)
                lows++;
        end
        chk("no_resume", lows, 32'd0);
        peek(16'h2004, d);
        chk("status_after_rst", d, 32'h2);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
